// File: rtl/port_share_arbiter.sv
// Round-robin arbiter that lets requesters A and B share one datapath port.
// It owns a one-entry registered output slot with a valid/ready handshake and keeps debug grant counters.
module port_share_arbiter #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             reqA,
  input  logic [WIDTH-1:0] dataA,
  output logic             ackA,
  input  logic             reqB,
  input  logic [WIDTH-1:0] dataB,
  output logic             ackB,
  output logic             outValid,
  output logic [WIDTH-1:0] outData,
  input  logic             outReady,
  output logic             grantSel,
  output logic [CNT_W-1:0] cntA,
  output logic [CNT_W-1:0] cntB
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_A = 2'd1,
    HOLD_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  state_t             state_q, state_d;
  logic               lastGrant_q, lastGrant_d;
  logic [WIDTH-1:0]   outData_q, outData_d;
  logic               grantSel_q, grantSel_d;
  logic [CNT_W-1:0]   cntA_q, cntA_d;
  logic [CNT_W-1:0]   cntB_q, cntB_d;

  logic slotFree;
  logic grantA;
  logic grantB;

  // A full slot may be drained and refilled on the same edge, so a ready consumer frees it.
  // Gating with resetN keeps the acks low while reset is held, whatever the requesters do.
  assign slotFree = (state_q == IDLE) || outReady;
  assign grantA   = resetN && slotFree && reqA && (!reqB || (lastGrant_q == SEL_B));
  assign grantB   = resetN && slotFree && reqB && (!reqA || (lastGrant_q == SEL_A));

  assign ackA     = grantA;
  assign ackB     = grantB;
  assign outValid = (state_q != IDLE);
  assign outData  = outData_q;
  assign grantSel = grantSel_q;
  assign cntA     = cntA_q;
  assign cntB     = cntB_q;

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    outData_d   = outData_q;
    grantSel_d  = grantSel_q;
    cntA_d      = cntA_q;
    cntB_d      = cntB_q;
    if (grantA) begin
      state_d     = HOLD_A;
      lastGrant_d = SEL_A;
      outData_d   = dataA;
      grantSel_d  = SEL_A;
      if (cntA_q != {CNT_W{1'b1}}) cntA_d = cntA_q + CNT_W'(1);
    end else if (grantB) begin
      state_d     = HOLD_B;
      lastGrant_d = SEL_B;
      outData_d   = dataB;
      grantSel_d  = SEL_B;
      if (cntB_q != {CNT_W{1'b1}}) cntB_d = cntB_q + CNT_W'(1);
    end else if ((state_q != IDLE) && outReady) begin
      // Drained with nothing to refill: data and select keep their last values.
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      lastGrant_q <= SEL_B;
      outData_q   <= '0;
      grantSel_q  <= SEL_A;
      cntA_q      <= '0;
      cntB_q      <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      outData_q   <= outData_d;
      grantSel_q  <= grantSel_d;
      cntA_q      <= cntA_d;
      cntB_q      <= cntB_d;
    end
  end

endmodule
